// File: rtl/egm_multi_channel.sv
// Multi-channel EGM stimulus/response engine: staggered stimulus pulses on a shared
// period, per-channel response latency measurement and saturating miss counters.
module egm_multi_channel #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int MISS_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clkin_50,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         period,
    input  logic [CNT_W-1:0]         pulse_width,
    input  logic [CNT_W-1:0]         phase_step,
    input  logic [NUM_CH-1:0]        response,
    output logic [NUM_CH-1:0]        stimulus,
    output logic [NUM_CH*CNT_W-1:0]  latency,
    output logic [NUM_CH-1:0]        lat_valid,
    output logic [NUM_CH*MISS_W-1:0] miss_count,
    output logic [NUM_CH-1:0]        egm_leds,
    output logic                     busy
);

    localparam int OFF_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] SYNC_LAG = CNT_W'(SYNC_STAGES - 1);

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_PULSE = 2'd1,
        CH_WAIT  = 2'd2
    } ch_state_e;

    logic             enable_q;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             busy_q, busy_d;

    ch_state_e              state_q     [NUM_CH];
    ch_state_e              state_d     [NUM_CH];
    logic [CNT_W-1:0]       lat_cnt_q   [NUM_CH];
    logic [CNT_W-1:0]       lat_cnt_d   [NUM_CH];
    logic [CNT_W-1:0]       pulse_rem_q [NUM_CH];
    logic [CNT_W-1:0]       pulse_rem_d [NUM_CH];
    logic [CNT_W-1:0]       latency_q   [NUM_CH];
    logic [CNT_W-1:0]       latency_d   [NUM_CH];
    logic [MISS_W-1:0]      miss_q      [NUM_CH];
    logic [MISS_W-1:0]      miss_d      [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_q      [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d      [NUM_CH];

    logic [NUM_CH-1:0] resp_prev_q, resp_prev_d;
    logic [NUM_CH-1:0] stim_q, stim_d;
    logic [NUM_CH-1:0] lat_valid_q, lat_valid_d;
    logic [NUM_CH-1:0] leds_q, leds_d;
    logic [NUM_CH-1:0] trig, hit, timeout, active;

    logic run_start, run_on;

    // Triggers start the cycle after the enable edge, once the latched config is in place.
    assign run_start = enable & ~enable_q;
    assign run_on    = enable & enable_q;

    always_comb begin : cfg_comb
        period_d = period_q;
        pulse_d  = pulse_q;
        phase_d  = phase_q;
        if (run_start) begin
            period_d = (period < CNT_W'(2)) ? CNT_W'(2) : period;
            pulse_d  = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
            phase_d  = phase_step;
        end
    end

    always_comb begin : cnt_comb
        if (run_start || !enable) begin
            period_cnt_d = '0;
        end else if (period_cnt_q == period_q - CNT_W'(1)) begin
            period_cnt_d = '0;
        end else begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
        end
    end

    // Edges whose lat_cnt is below the synchroniser lag predate the stimulus and are ignored.
    always_comb begin : event_comb
        trig    = '0;
        hit     = '0;
        timeout = '0;
        active  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            trig[ch]    = run_on &&
                          (OFF_W'(period_cnt_q) == OFF_W'(ch) * OFF_W'(phase_q));
            hit[ch]     = sync_q[ch][SYNC_STAGES-1] && !resp_prev_q[ch] &&
                          (lat_cnt_q[ch] >= SYNC_LAG);
            timeout[ch] = (lat_cnt_q[ch] == period_q - CNT_W'(2));
            active[ch]  = (state_q[ch] != CH_IDLE);
        end
    end

    always_comb begin : ch_comb
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch]     = state_q[ch];
            lat_cnt_d[ch]   = lat_cnt_q[ch];
            pulse_rem_d[ch] = pulse_rem_q[ch];
            latency_d[ch]   = latency_q[ch];
            miss_d[ch]      = miss_q[ch];
            stim_d[ch]      = stim_q[ch];
            lat_valid_d[ch] = 1'b0;
            sync_d[ch]      = {sync_q[ch][SYNC_STAGES-2:0], response[ch]};
            resp_prev_d[ch] = sync_q[ch][SYNC_STAGES-1];
            case (state_q[ch])
                CH_IDLE: begin
                    if (trig[ch]) begin
                        state_d[ch]     = CH_PULSE;
                        stim_d[ch]      = 1'b1;
                        lat_cnt_d[ch]   = '0;
                        pulse_rem_d[ch] = pulse_q - CNT_W'(1);
                    end
                end
                CH_PULSE, CH_WAIT: begin
                    lat_cnt_d[ch] = (lat_cnt_q[ch] == '1) ? lat_cnt_q[ch]
                                                          : lat_cnt_q[ch] + CNT_W'(1);
                    if (hit[ch]) begin
                        latency_d[ch]   = lat_cnt_q[ch] - SYNC_LAG;
                        lat_valid_d[ch] = 1'b1;
                        stim_d[ch]      = 1'b0;
                        state_d[ch]     = CH_IDLE;
                    end else if (timeout[ch]) begin
                        if (miss_q[ch] != '1) begin
                            miss_d[ch] = miss_q[ch] + MISS_W'(1);
                        end
                        stim_d[ch]  = 1'b0;
                        state_d[ch] = CH_IDLE;
                    end else if (state_q[ch] == CH_PULSE) begin
                        if (pulse_rem_q[ch] == '0) begin
                            stim_d[ch]  = 1'b0;
                            state_d[ch] = CH_WAIT;
                        end else begin
                            pulse_rem_d[ch] = pulse_rem_q[ch] - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[ch] = CH_IDLE;
                    stim_d[ch]  = 1'b0;
                end
            endcase
            if (run_start) begin
                latency_d[ch] = '0;
                miss_d[ch]    = '0;
            end
            leds_d[ch] = (state_d[ch] != CH_IDLE);
        end
    end

    assign busy_d = enable | (|active);

    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            enable_q     <= 1'b0;
            period_q     <= '0;
            pulse_q      <= '0;
            phase_q      <= '0;
            period_cnt_q <= '0;
            busy_q       <= 1'b0;
            resp_prev_q  <= '0;
            stim_q       <= '0;
            lat_valid_q  <= '0;
            leds_q       <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]     <= CH_IDLE;
                lat_cnt_q[ch]   <= '0;
                pulse_rem_q[ch] <= '0;
                latency_q[ch]   <= '0;
                miss_q[ch]      <= '0;
                sync_q[ch]      <= '0;
            end
        end else begin
            enable_q     <= enable;
            period_q     <= period_d;
            pulse_q      <= pulse_d;
            phase_q      <= phase_d;
            period_cnt_q <= period_cnt_d;
            busy_q       <= busy_d;
            resp_prev_q  <= resp_prev_d;
            stim_q       <= stim_d;
            lat_valid_q  <= lat_valid_d;
            leds_q       <= leds_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]     <= state_d[ch];
                lat_cnt_q[ch]   <= lat_cnt_d[ch];
                pulse_rem_q[ch] <= pulse_rem_d[ch];
                latency_q[ch]   <= latency_d[ch];
                miss_q[ch]      <= miss_d[ch];
                sync_q[ch]      <= sync_d[ch];
            end
        end
    end

    assign stimulus  = stim_q;
    assign lat_valid = lat_valid_q;
    assign egm_leds  = leds_q;
    assign busy      = busy_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign latency[gi*CNT_W +: CNT_W]     = latency_q[gi];
        assign miss_count[gi*MISS_W +: MISS_W] = miss_q[gi];
    end

endmodule

// File: tb/tb_egm_multi_channel.sv
// Directed bench for egm_multi_channel: hit, stagger, miss saturation, stuck-high
// response, clamping, enable drop and asynchronous reset.
module tb_egm_multi_channel;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int MISS_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic                     clkin_50;
    logic                     rst;
    logic                     enable;
    logic [CNT_W-1:0]         period;
    logic [CNT_W-1:0]         pulse_width;
    logic [CNT_W-1:0]         phase_step;
    logic [NUM_CH-1:0]        response;
    logic [NUM_CH-1:0]        stimulus;
    logic [NUM_CH*CNT_W-1:0]  latency;
    logic [NUM_CH-1:0]        lat_valid;
    logic [NUM_CH*MISS_W-1:0] miss_count;
    logic [NUM_CH-1:0]        egm_leds;
    logic                     busy;

    int vectors     = 0;
    int miscompares = 0;

    egm_multi_channel #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .MISS_W      (MISS_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clkin_50    (clkin_50),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .pulse_width (pulse_width),
        .phase_step  (phase_step),
        .response    (response),
        .stimulus    (stimulus),
        .latency     (latency),
        .lat_valid   (lat_valid),
        .miss_count  (miss_count),
        .egm_leds    (egm_leds),
        .busy        (busy)
    );

    initial clkin_50 = 1'b0;
    always #5 clkin_50 = ~clkin_50;

    function automatic logic [CNT_W-1:0] lat_of(input int ch);
        return latency[ch*CNT_W +: CNT_W];
    endfunction

    function automatic logic [MISS_W-1:0] miss_of(input int ch);
        return miss_count[ch*MISS_W +: MISS_W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] pw,
                           input logic [CNT_W-1:0] ph, input logic [NUM_CH-1:0] resp);
        enable = 1'b0;
        repeat (3) @(negedge clkin_50);
        period      = per;
        pulse_width = pw;
        phase_step  = ph;
        response    = resp;
        repeat (3) @(negedge clkin_50);
        enable = 1'b1;
    endtask

    // Channel 0 must rise exactly two cycles after enable is raised.
    task automatic wait_rise(input string tag);
        int steps;
        steps = 0;
        while (!stimulus[0] && steps < 50) begin
            @(negedge clkin_50);
            steps++;
        end
        check(tag, steps, 2);
    endtask

    initial begin
        int hi_cnt, lv_cnt, lv_k, led_cnt, steps, rises_after;
        int rise_k [NUM_CH];
        int lv_ch  [NUM_CH];
        int rises  [NUM_CH];
        logic [NUM_CH-1:0] prev;

        rst = 1'b1; enable = 1'b0; response = '0;
        period = '0; pulse_width = '0; phase_step = '0;
        repeat (3) @(negedge clkin_50);
        check("rst_stimulus", stimulus, 0);
        check("rst_latency", latency, 0);
        check("rst_miss", miss_count, 0);
        check("rst_misc", {lat_valid, egm_leds, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clkin_50);

        // Single hit: response sampled 10 cycles after stimulus rise.
        restart(16'd100, 16'd5, 16'd200, 4'b0000);
        wait_rise("hit_rise");
        hi_cnt = 0; lv_cnt = 0; lv_k = -1; led_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (stimulus[0]) hi_cnt++;
            if (egm_leds[0]) led_cnt++;
            if (lat_valid[0]) begin
                lv_cnt++;
                if (lv_k < 0) lv_k = k;
            end
            if (k == 9)  response[0] = 1'b1;
            if (k == 29) response[0] = 1'b0;
            @(negedge clkin_50);
        end
        check("hit_pulse_len", hi_cnt, 5);
        check("hit_lv_count", lv_cnt, 1);
        check("hit_lv_cycle", lv_k, 12);
        check("hit_latency", lat_of(0), 10);
        check("hit_miss", miss_of(0), 0);
        check("hit_leds", led_cnt, 12);
        check("hit_other_ch", stimulus[3:1], 0);

        // Stagger by 20, channel i answers after 3+i, then silence for 300 periods.
        restart(16'd100, 16'd5, 16'd20, 4'b0000);
        wait_rise("stag_rise");
        check("stag_lat_cleared", lat_of(0), 0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rise_k[ch] = -1;
            lv_ch[ch]  = 0;
        end
        led_cnt = 0;
        for (int k = 0; k < 30100; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (stimulus[ch] && rise_k[ch] < 0) rise_k[ch] = k;
                if (k < 100 && lat_valid[ch]) lv_ch[ch]++;
                if (k == 21*ch + 2)  response[ch] = 1'b1;
                if (k == 21*ch + 12) response[ch] = 1'b0;
            end
            if (k >= 100 && k < 200 && egm_leds[0]) led_cnt++;
            if (k == 99) begin
                check("stag_lat0", lat_of(0), 3);
                check("stag_lat1", lat_of(1), 4);
                check("stag_lat2", lat_of(2), 5);
                check("stag_lat3", lat_of(3), 6);
                check("stag_miss0_p1", miss_of(0), 0);
            end
            if (k == 199) check("miss0_first", miss_of(0), 1);
            if (k == 1099) begin
                check("miss0_ten", miss_of(0), 10);
                check("miss3_nine", miss_of(3), 9);
            end
            @(negedge clkin_50);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("stag_rise_k%0d", ch), rise_k[ch], 20*ch);
            check($sformatf("stag_lv%0d", ch), lv_ch[ch], 1);
            check($sformatf("sat_miss%0d", ch), miss_of(ch), 255);
            check($sformatf("sat_lat%0d", ch), lat_of(ch), 3 + ch);
        end
        check("miss_leds_period", led_cnt, 99);

        enable = 1'b0;
        steps = 0;
        while (busy && steps < 300) begin
            @(negedge clkin_50);
            steps++;
        end
        check("drop_busy_low", busy, 0);

        // Stuck-high response on ch0, then enable drop during WAIT with a late hit.
        restart(16'd20, 16'd3, 16'd200, 4'b0001);
        wait_rise("stuck_rise");
        lv_cnt = 0; rises_after = 0; prev = stimulus;
        for (int k = 0; k <= 100; k++) begin
            if (k < 60 && lat_valid[0]) lv_cnt++;
            if (k > 60 && stimulus[0] && !prev[0]) rises_after++;
            prev = stimulus;
            if (k == 19) check("stuck_miss_1", miss_of(0), 1);
            if (k == 59) check("stuck_miss_3", miss_of(0), 3);
            if (k == 60) begin
                enable   = 1'b0;
                response = '0;
            end
            if (k == 66) response[0] = 1'b1;
            if (k == 69) begin
                check("drop_lv", lat_valid[0], 1);
                check("drop_latency", lat_of(0), 7);
                check("drop_busy_hold", busy, 1);
            end
            if (k == 70) check("drop_busy_fall", {busy, lat_valid[0]}, 0);
            @(negedge clkin_50);
        end
        response = '0;
        check("stuck_no_lv", lv_cnt, 0);
        check("drop_miss_kept", miss_of(0), 3);
        check("drop_no_retrigger", rises_after, 0);

        // Clamp: period 1 -> 2, pulse 0 -> 1; phase 0 fires all channels together.
        restart(16'd1, 16'd0, 16'd0, 4'b0000);
        wait_rise("clamp_rise");
        hi_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (stimulus[0]) hi_cnt++;
            if (k == 0) check("clamp_all_ch", stimulus, 4'hF);
            if (k == 1) begin
                check("clamp_drop", stimulus, 0);
                check("clamp_miss1", miss_of(0), 1);
            end
            if (k == 9) check("clamp_miss3_5", miss_of(3), 5);
            @(negedge clkin_50);
        end
        check("clamp_hi_cnt", hi_cnt, 5);

        // Phase 60 on period 100: channels 2 and 3 are out of range.
        restart(16'd100, 16'd5, 16'd60, 4'b0000);
        wait_rise("range_rise");
        prev = '0;
        for (int ch = 0; ch < NUM_CH; ch++) rises[ch] = 0;
        for (int k = 0; k < 200; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (stimulus[ch] && !prev[ch]) rises[ch]++;
            end
            prev = stimulus;
            @(negedge clkin_50);
        end
        check("range_ch0", rises[0], 2);
        check("range_ch1", rises[1], 2);
        check("range_ch23", rises[2] + rises[3], 0);
        check("range_pulse_now", stimulus[0], 1);
        check("range_miss0", miss_of(0), 2);

        // Asynchronous reset while ch0 is in PULSE.
        #1;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check("arst_stimulus", stimulus, 0);
        check("arst_misc", {lat_valid, egm_leds, busy}, 0);
        check("arst_miss", miss_count, 0);
        check("arst_latency", latency, 0);
        repeat (2) @(negedge clkin_50);
        check("arst_hold", {stimulus, lat_valid}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clkin_50);
        check("arst_after", {stimulus, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
